// File: rtl/icb_arbiter_2to1.sv
// Two-master to one-slave ICB arbiter: combinational command mux with a stall lock,
// and an in-order ID FIFO that steers each downstream response back to its issuer.
module icb_arbiter_2to1 #(
    parameter string arb_mode         = "round_robin",
    parameter int    outstanding_n    = 4,
    parameter int    simulation_delay = 1
) (
    input  logic        s_icb_aclk,
    input  logic        s_icb_aresetn,

    input  logic [31:0] s0_icb_cmd_addr,
    input  logic        s0_icb_cmd_read,
    input  logic [31:0] s0_icb_cmd_wdata,
    input  logic [3:0]  s0_icb_cmd_wmask,
    input  logic        s0_icb_cmd_valid,
    output logic        s0_icb_cmd_ready,
    output logic [31:0] s0_icb_rsp_rdata,
    output logic        s0_icb_rsp_err,
    output logic        s0_icb_rsp_valid,
    input  logic        s0_icb_rsp_ready,

    input  logic [31:0] s1_icb_cmd_addr,
    input  logic        s1_icb_cmd_read,
    input  logic [31:0] s1_icb_cmd_wdata,
    input  logic [3:0]  s1_icb_cmd_wmask,
    input  logic        s1_icb_cmd_valid,
    output logic        s1_icb_cmd_ready,
    output logic [31:0] s1_icb_rsp_rdata,
    output logic        s1_icb_rsp_err,
    output logic        s1_icb_rsp_valid,
    input  logic        s1_icb_rsp_ready,

    output logic [31:0] m_icb_cmd_addr,
    output logic        m_icb_cmd_read,
    output logic [31:0] m_icb_cmd_wdata,
    output logic [3:0]  m_icb_cmd_wmask,
    output logic        m_icb_cmd_valid,
    input  logic        m_icb_cmd_ready,
    input  logic [31:0] m_icb_rsp_rdata,
    input  logic        m_icb_rsp_err,
    input  logic        m_icb_rsp_valid,
    output logic        m_icb_rsp_ready
);

    localparam int ptr_w = $clog2(outstanding_n);
    localparam logic [ptr_w:0] ptr_one = 1;
    localparam bit fixed_mode = (arb_mode == "fixed");

    // Register updates are delay-free; simulation_delay is kept only so existing
    // instantiations keep elaborating, and is range-checked with the depth.
    if (outstanding_n < 2 || outstanding_n > 16 ||
        (outstanding_n & (outstanding_n - 1)) != 0 || simulation_delay < 0) begin : g_param_check
        $error("icb_arbiter_2to1: outstanding_n must be a power of 2 in 2..16");
    end

    // Grant encoding: 0 = s0 (instruction fetch), 1 = s1 (data).
    logic             grant;
    logic             lock;
    logic             locked_grant;
    logic             last_grant;
    logic [ptr_w:0]   wptr;
    logic [ptr_w:0]   rptr;
    logic [outstanding_n-1:0] id_mem;
    logic             fifo_empty;
    logic             fifo_full;
    logic             head_id;
    logic             cmd_hs;
    logic             rsp_pop;

    always_comb begin
        grant = 1'b0;
        if (lock) begin
            grant = locked_grant;
        end else if (s0_icb_cmd_valid && s1_icb_cmd_valid) begin
            grant = fixed_mode ? 1'b1 : ~last_grant;
        end else if (s1_icb_cmd_valid) begin
            grant = 1'b1;
        end
    end

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[ptr_w] != rptr[ptr_w]) &&
                        (wptr[ptr_w-1:0] == rptr[ptr_w-1:0]);
    assign head_id    = id_mem[rptr[ptr_w-1:0]];

    // Full blocks commands regardless of a same-cycle pop, keeping ready off the rsp path.
    assign m_icb_cmd_addr   = grant ? s1_icb_cmd_addr  : s0_icb_cmd_addr;
    assign m_icb_cmd_read   = grant ? s1_icb_cmd_read  : s0_icb_cmd_read;
    assign m_icb_cmd_wdata  = grant ? s1_icb_cmd_wdata : s0_icb_cmd_wdata;
    assign m_icb_cmd_wmask  = grant ? s1_icb_cmd_wmask : s0_icb_cmd_wmask;
    assign m_icb_cmd_valid  = (grant ? s1_icb_cmd_valid : s0_icb_cmd_valid) & ~fifo_full;
    assign s0_icb_cmd_ready = m_icb_cmd_ready & ~fifo_full & ~grant;
    assign s1_icb_cmd_ready = m_icb_cmd_ready & ~fifo_full &  grant;
    assign cmd_hs           = m_icb_cmd_valid & m_icb_cmd_ready;

    assign s0_icb_rsp_rdata = m_icb_rsp_rdata;
    assign s0_icb_rsp_err   = m_icb_rsp_err;
    assign s1_icb_rsp_rdata = m_icb_rsp_rdata;
    assign s1_icb_rsp_err   = m_icb_rsp_err;
    assign s0_icb_rsp_valid = m_icb_rsp_valid & ~fifo_empty & ~head_id;
    assign s1_icb_rsp_valid = m_icb_rsp_valid & ~fifo_empty &  head_id;

    // A response with nothing outstanding is accepted and dropped so the slave cannot hang.
    assign m_icb_rsp_ready = fifo_empty ? m_icb_rsp_valid
                                        : (head_id ? s1_icb_rsp_ready : s0_icb_rsp_ready);
    assign rsp_pop         = m_icb_rsp_valid & m_icb_rsp_ready & ~fifo_empty;

    always_ff @(posedge s_icb_aclk or negedge s_icb_aresetn) begin
        if (!s_icb_aresetn) begin
            lock         <= 1'b0;
            locked_grant <= 1'b0;
            last_grant   <= 1'b0;
            wptr         <= '0;
            rptr         <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            lock         <= m_icb_cmd_valid & ~m_icb_cmd_ready;
            locked_grant <= grant;
            if (cmd_hs) begin
                last_grant <= grant;
                wptr       <= wptr + ptr_one;
            end
            if (rsp_pop) begin
                rptr <= rptr + ptr_one;
            end
        end
    end

    // NOTE: ID storage is not reset; entries are only read between pointers that reset clears.
    always_ff @(posedge s_icb_aclk) begin
        if (cmd_hs) begin
            id_mem[wptr[ptr_w-1:0]] <= grant;
        end
    end

endmodule
